// File: rtl/alu_muldiv_seq_if.sv
// Request/result and ALU-operand bundle between EX, the mul/div sequencer and the shared ALU.
interface alu_muldiv_seq_if;
  logic        start;
  logic        op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, src1, src2, alu_result,
    input  alu_src1, alu_src2, alu_ctrl, busy, done, hi, lo
  );

  modport slave (
    input  start, op, src1, src2, alu_result,
    output alu_src1, alu_src2, alu_ctrl, busy, done, hi, lo
  );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle 32-bit unsigned MULU/DIVU sequencer that borrows the EX-stage ALU for
// shift-add multiply and restoring divide, keeping a HI/LO result pair.
module alu_muldiv_seq #(
  parameter int unsigned ITER = 32
) (
  input logic           clk_i,
  input logic           rst_i,
  alu_muldiv_seq_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] ALU_NOP = 4'b0000;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  logic [1:0]  state;
  logic        op;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] opnd;
  logic [5:0]  cnt;

  logic [31:0] rs;
  logic [31:0] addend;
  logic        carry;
  logic        ge;

  // ALU has no carry-out: an unsigned sum smaller than its addend hi means it wrapped.
  always_comb begin
    rs     = {hi[30:0], lo[31]};
    addend = lo[0] ? opnd : '0;
    carry  = (bus.alu_result < hi);
    ge     = (rs >= opnd);

    bus.alu_ctrl = ALU_NOP;
    bus.alu_src1 = '0;
    bus.alu_src2 = '0;
    if (state == RUN) begin
      if (op) begin
        bus.alu_ctrl = ALU_SUB;
        bus.alu_src1 = rs;
        bus.alu_src2 = opnd;
      end else begin
        bus.alu_ctrl = ALU_ADD;
        bus.alu_src1 = hi;
        bus.alu_src2 = addend;
      end
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.hi   = hi;
  assign bus.lo   = lo;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state <= IDLE;
      op    <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      opnd  <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            op  <= bus.op;
            cnt <= '0;
            if (bus.op && (bus.src2 == '0)) begin
              hi    <= bus.src1;
              lo    <= '1;
              opnd  <= '0;
              state <= DONE;
            end else begin
              // MULU keeps the multiplier in lo and the multiplicand aside; DIVU the reverse.
              hi    <= '0;
              lo    <= bus.op ? bus.src1 : bus.src2;
              opnd  <= bus.op ? bus.src2 : bus.src1;
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (op) begin
            if (ge) begin
              hi <= bus.alu_result;
              lo <= {lo[30:0], 1'b1};
            end else begin
              hi <= rs;
              lo <= {lo[30:0], 1'b0};
            end
          end else begin
            hi <= {carry, bus.alu_result[31:1]};
            lo <= {bus.alu_result[0], lo[31:1]};
          end
          cnt <= cnt + 6'd1;
          if (cnt == 6'(ITER - 1)) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
